// File: rtl/multi_tick_divider.sv
// multi_tick_divider: per-channel runtime-programmable clock-enable (tick) and 50% square-wave generator
//
// Optional feature macro: TICK_SYNC_EN (enables the global phase restart input sync)
//
// Ports:
//   clk_in    in   system clock, all state changes on its rising edge
//   rst       in   synchronous active-high reset
//   en        in   per-channel count enable
//   div_load  in   divisor load request (valid)
//   div_sel   in   target channel of the load
//   div_value in   new divisor value (0 and 1 both mean divide-by-1)
//   div_ready out  load port can accept a request
//   sync      in   global phase restart (only used with TICK_SYNC_EN)
//   tick      out  one-cycle strobe per channel period
//   clk_out   out  square wave per channel, period 2*divisor
module multi_tick_divider #(
   parameter int CHANNELS    = 4,
   parameter int WIDTH       = 16,
   parameter int DEFAULT_DIV = 2,
   localparam int SEL_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                clk_in,
   input  logic                rst,
   input  logic [CHANNELS-1:0] en,
   input  logic                div_load,
   input  logic [SEL_W-1:0]    div_sel,
   input  logic [WIDTH-1:0]    div_value,
   output logic                div_ready,
   input  logic                sync,
   output logic [CHANNELS-1:0] tick,
   output logic [CHANNELS-1:0] clk_out
);
   logic [WIDTH-1:0]    cnt_q [CHANNELS];
   logic [WIDTH-1:0]    cnt_d [CHANNELS];
   logic [WIDTH-1:0]    div_q [CHANNELS];
   logic [WIDTH-1:0]    div_d [CHANNELS];
   logic [WIDTH-1:0]    eff   [CHANNELS];
   logic [CHANNELS-1:0] tick_q, tick_d, clk_q, clk_d, bnd, hit;
   logic                pend_q, pend_d, done_q, done_d, rdy_q, rdy_d;
   logic [SEL_W-1:0]    sel_q, sel_d;
   logic [WIDTH-1:0]    val_q, val_d;

   always_comb begin
      cnt_d  = cnt_q;
      div_d  = div_q;
      tick_d = '0;
      clk_d  = clk_q;
      pend_d = pend_q;
      done_d = 1'b0;
      // ready returns one cycle after the shadow value has been applied
      rdy_d  = rdy_q | done_q;
      sel_d  = sel_q;
      val_d  = val_q;
      for (int i = 0; i < CHANNELS; i++) begin
         eff[i] = (div_q[i] == '0) ? WIDTH'(1) : div_q[i];
         bnd[i] = en[i] && (cnt_q[i] == eff[i] - WIDTH'(1));
         hit[i] = pend_q && (sel_q == SEL_W'(i));
         if (en[i]) begin
            cnt_d[i]  = bnd[i] ? '0 : cnt_q[i] + WIDTH'(1);
            tick_d[i] = bnd[i];
            clk_d[i]  = clk_q[i] ^ bnd[i];
         end
         // a disabled channel has no period in progress to protect, so apply at once
         if (hit[i] && (bnd[i] || !en[i])) begin
            div_d[i] = val_q;
            cnt_d[i] = '0;
            pend_d   = 1'b0;
            done_d   = 1'b1;
         end
      end
`ifdef TICK_SYNC_EN
      if (sync) begin
         tick_d = '0;
         clk_d  = '0;
         for (int i = 0; i < CHANNELS; i++) begin
            cnt_d[i] = '0;
            div_d[i] = hit[i] ? val_q : div_q[i];
         end
         pend_d = 1'b0;
         done_d = pend_q;
      end
`endif
      // acceptance comes last so a load captured alongside sync stays pending
      if (div_load && rdy_q && (int'(div_sel) < CHANNELS)) begin
         pend_d = 1'b1;
         rdy_d  = 1'b0;
         sel_d  = div_sel;
         val_d  = div_value;
      end
   end

`ifndef TICK_SYNC_EN
   logic unused_sync;
   assign unused_sync = sync;
`endif

   always_ff @(posedge clk_in) begin
      if (rst) begin
         cnt_q  <= '{default: '0};
         div_q  <= '{default: WIDTH'(DEFAULT_DIV)};
         tick_q <= '0;
         clk_q  <= '0;
         pend_q <= 1'b0;
         done_q <= 1'b0;
         rdy_q  <= 1'b1;
         sel_q  <= '0;
         val_q  <= '0;
      end else begin
         cnt_q  <= cnt_d;
         div_q  <= div_d;
         tick_q <= tick_d;
         clk_q  <= clk_d;
         pend_q <= pend_d;
         done_q <= done_d;
         rdy_q  <= rdy_d;
         sel_q  <= sel_d;
         val_q  <= val_d;
      end
   end

   assign tick      = tick_q;
   assign clk_out   = clk_q;
   assign div_ready = rdy_q;
endmodule

// File: tb/tb_multi_tick_divider.sv
// tb_multi_tick_divider: randomized scoreboard bench for multi_tick_divider
module tb_multi_tick_divider;
   // three channels so that a select value of 3 is a genuine out-of-range target
   localparam int CH  = 3;
   localparam int W   = 16;
   localparam int DEF = 2;
   localparam int SW  = 2;

   typedef struct packed {
      logic [CH-1:0] tk;
      logic [CH-1:0] co;
      logic          rd;
   } exp_t;

   logic          clk_in = 1'b0;
   logic          rst, div_load, div_ready, sync;
   logic [CH-1:0] en, tick, clk_out;
   logic [SW-1:0] div_sel;
   logic [W-1:0]  div_value;

   int   checks = 0;
   int   passed = 0;
   int   cyc    = 0;
   exp_t q[$];

   multi_tick_divider #(.CHANNELS(CH), .WIDTH(W), .DEFAULT_DIV(DEF)) dut (
      .clk_in(clk_in), .rst(rst), .en(en), .div_load(div_load), .div_sel(div_sel),
      .div_value(div_value), .div_ready(div_ready), .sync(sync), .tick(tick), .clk_out(clk_out)
   );

   always #5 clk_in = ~clk_in;

   // Reference model: each channel counts enabled edges since its last period
   // end; a period ends when that count reaches the divisor. The load port is
   // ready exactly when nothing is pending and nothing was applied on this edge.
   int  m_div [CH];
   int  m_el  [CH];
   bit  m_tk  [CH];
   bit  m_co  [CH];
   bit  m_pend, m_rdy;
   int  m_sel, m_val;

   always @(posedge clk_in) begin : model
      int   p;
      bit   b, applied, synced;
      exp_t e;
      applied = 0;
      synced  = 0;
      if (rst) begin
         for (int i = 0; i < CH; i++) begin
            m_div[i] = DEF; m_el[i] = 0; m_tk[i] = 0; m_co[i] = 0;
         end
         m_pend = 0;
         m_rdy  = 1;
      end else begin
`ifdef TICK_SYNC_EN
         if (sync) begin
            synced = 1;
            for (int i = 0; i < CH; i++) begin
               m_el[i] = 0; m_tk[i] = 0; m_co[i] = 0;
            end
            if (m_pend) begin
               m_div[m_sel] = m_val;
               m_pend = 0;
               applied = 1;
            end
         end
`endif
         if (!synced) begin
            for (int i = 0; i < CH; i++) begin
               p = (m_div[i] < 1) ? 1 : m_div[i];
               b = 0;
               m_tk[i] = 0;
               if (en[i]) begin
                  m_el[i]++;
                  if (m_el[i] == p) begin
                     b = 1; m_el[i] = 0; m_tk[i] = 1; m_co[i] = !m_co[i];
                  end
               end
               if (m_pend && m_sel == i && (b || !en[i])) begin
                  m_div[i] = m_val; m_el[i] = 0; m_pend = 0; applied = 1;
               end
            end
         end
         if (div_load && m_rdy && int'(div_sel) < CH) begin
            m_pend = 1;
            m_sel  = int'(div_sel);
            m_val  = int'(div_value);
         end
         m_rdy = !m_pend && !applied;
      end
      for (int i = 0; i < CH; i++) begin
         e.tk[i] = m_tk[i];
         e.co[i] = m_co[i];
      end
      e.rd = m_rdy;
      q.push_back(e);
      cyc++;
   end

   always @(negedge clk_in) begin : monitor
      exp_t e;
      if (q.size() > 0) begin
         e = q.pop_front();
         checks += 3;
         if (tick === e.tk) passed++;
         else $display("FAIL tick cyc=%0d got=%b exp=%b", cyc, tick, e.tk);
         if (clk_out === e.co) passed++;
         else $display("FAIL clk_out cyc=%0d got=%b exp=%b", cyc, clk_out, e.co);
         if (div_ready === e.rd) passed++;
         else $display("FAIL div_ready cyc=%0d got=%b exp=%b", cyc, div_ready, e.rd);
      end
   end

   task automatic load(input int sel, input int val);
      int n = 0;
      while (div_ready !== 1'b1 && n < 200) begin
         @(negedge clk_in);
         n++;
      end
      if (div_ready !== 1'b1) begin
         checks++;
         $display("FAIL load_wait cyc=%0d got=div_ready %b exp=1 within 200 cycles", cyc, div_ready);
      end
      div_load  = 1'b1;
      div_sel   = SW'(sel);
      div_value = W'(val);
      @(negedge clk_in);
      div_load  = 1'b0;
   endtask

   initial begin
      rst = 1'b1; en = '1; div_load = 1'b0; div_sel = '0; div_value = '0; sync = 1'b0;
      repeat (3) @(negedge clk_in);
      rst = 1'b0;
      repeat (12) @(negedge clk_in);
      load(1, 5);
      repeat (20) @(negedge clk_in);
      load(0, 0);
      repeat (6) @(negedge clk_in);
      load(0, 1);
      repeat (6) @(negedge clk_in);
      en = 3'b011;
      repeat (7) @(negedge clk_in);
      en = '1;
      repeat (8) @(negedge clk_in);
      load(3, 4);
      repeat (4) @(negedge clk_in);
      load(2, 3);
      repeat (2) @(negedge clk_in);
      sync = 1'b1;
      @(negedge clk_in);
      sync = 1'b0;
      repeat (10) @(negedge clk_in);
      load(2, 6);
      @(negedge clk_in);
      rst = 1'b1;
      @(negedge clk_in);
      rst = 1'b0;
      repeat (10) @(negedge clk_in);
      repeat (500) begin
         en        = ($urandom % 4 == 0) ? CH'($urandom) : '1;
         div_load  = ($urandom % 5 == 0);
         div_sel   = SW'($urandom_range(0, 3));
         div_value = W'($urandom_range(0, 6));
         sync      = ($urandom % 40 == 0);
         rst       = ($urandom % 90 == 0);
         @(negedge clk_in);
      end
      rst = 1'b0; sync = 1'b0; div_load = 1'b0; en = '1;
      repeat (10) @(negedge clk_in);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
